rv32_fetch_unit: RTL and testbench

// - Instruction-fetch front end feeding the IF/ID register of the 5-stage RV32 pipeline.
// - Owns the PC and issues word reads to instruction memory over a valid/ready request channel.
// - Buffers in-order responses in a small prefetch FIFO and presents {pc, instruction} to decode with valid/ready.
// - Redirects (branch/jump resolve) flush the FIFO and discard stale in-flight responses.

---
 rtl/rv32_pipeline_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/rv32_fetch_unit.sv | 126 ++++++++++++
 tb/tb_rv32_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipeline_pkg.sv
// Shared types for the RV32 5-stage pipeline.
// Fetch-side entry, NOP constant and fetch FSM states.
package rv32_pipeline_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RV32_NOP = 32'h00000013;

  typedef struct packed {
    word_t pc;
    word_t instruction;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between imem responses and decode.
// Head is combinational; flush wins over same-cycle push/pop.
module fetch_fifo
  import rv32_pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t data,
  output logic [AW:0]  count,
  output fetch_entry_t head
);

  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign full    = count == FULL_C;
  assign do_pop  = pop && count != '0 && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush)
  );

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch front end: PC, imem request
// credits, stale-response dropping and prefetch FIFO.
module rv32_fetch_unit
  import rv32_pipeline_pkg::*;
#(
  parameter word_t PC_RESET_VALUE  = 32'h00000000,
  parameter int    FIFO_DEPTH      = 4,
  parameter int    MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] OUT_LIM   = CW'(MAX_OUTSTANDING);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  word_t         pc;
  word_t         rsp_pc;
  word_t         target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_sum;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          credit_ok;
  logic          hs;
  logic          keep;
  logic          drop;
  logic          pop;
  logic          unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];
  assign target      = {redirect_pc[31:2], 2'b00};

  assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok  = credit_sum < DEPTH_LIM
                   && outstanding < OUT_LIM;

  assign imem_req_valid = state == FS_FETCH
                       && credit_ok
                       && !redirect_valid;
  assign imem_req_addr  = pc;
  assign hs = imem_req_valid && imem_req_ready;

  assign drop = imem_rsp_valid && drop_cnt != '0;
  assign keep = imem_rsp_valid && drop_cnt == '0;

  assign if_valid       = fifo_count != '0;
  assign pop            = if_valid && if_ready;
  assign if_instruction = if_valid ? head.instruction : RV32_NOP;
  assign if_pc          = if_valid ? head.pc : '0;

  assign push_entry = '{pc: rsp_pc, instruction: imem_rsp_data};

  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE:  if (fetch_en)  state_nxt = FS_FETCH;
      FS_FETCH: if (!fetch_en) state_nxt = FS_HOLD;
      FS_HOLD:  if (fetch_en)  state_nxt = FS_FETCH;
      default:  state_nxt = FS_IDLE;
    endcase
  end

  always_comb begin
    out_nxt = outstanding;
    if (hs && !imem_rsp_valid)
      out_nxt = outstanding + CW'(1);
    else if (!hs && imem_rsp_valid)
      out_nxt = outstanding - CW'(1);
  end

  // On redirect every live request becomes stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FS_IDLE;
      pc          <= PC_RESET_VALUE;
      rsp_pc      <= PC_RESET_VALUE;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (redirect_valid) begin
        pc       <= target;
        rsp_pc   <= target;
        drop_cnt <= out_nxt;
      end else begin
        if (hs)   pc       <= pc + 32'd4;
        if (keep) rsp_pc   <= rsp_pc + 32'd4;
        if (drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .flush (redirect_valid),
    .data  (push_entry),
    .count (fifo_count),
    .head  (head)
  );

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed bench for rv32_fetch_unit with an in-order
// variable-latency imem model and decode-side checker.
module tb_rv32_fetch_unit;
  import rv32_pipeline_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  fetch_en = 1'b0;
  logic  redirect_valid = 1'b0;
  word_t redirect_pc = '0;
  logic  imem_req_valid;
  logic  imem_req_ready = 1'b1;
  word_t imem_req_addr;
  logic  imem_rsp_valid = 1'b0;
  word_t imem_rsp_data = '0;
  logic  if_valid;
  logic  if_ready = 1'b1;
  word_t if_instruction;
  word_t if_pc;

  rv32_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    due;
    word_t addr;
  } mreq_t;

  mreq_t q[$];
  word_t req_log[$];
  word_t pop_log[$];
  int    lat = 1;
  int    edge_n = 0;
  int    issued = 0;
  int    popped = 0;
  int    first_acc = -1;
  int    first_vld = -1;
  word_t exp_pc = '0;
  word_t exp_req = '0;
  int    n_chk = 0;
  int    n_pass = 0;

  function automatic word_t mdata(word_t a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(string tag, word_t got, word_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  // imem model and decode-side scoreboard
  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      q.delete();
      req_log.delete();
      pop_log.delete();
      exp_pc  = '0;
      exp_req = '0;
    end else begin
      if (imem_rsp_valid) void'(q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        q.push_back('{due: edge_n + lat - 1,
                      addr: imem_req_addr});
        issued++;
        if (first_acc < 0) first_acc = edge_n;
      end
      if (if_valid && first_vld < 0) first_vld = edge_n;
      if (redirect_valid) begin
        chk("req_on_redirect",
            32'(imem_req_valid && imem_req_ready), 0);
        exp_pc  = {redirect_pc[31:2], 2'b00};
        exp_req = {redirect_pc[31:2], 2'b00};
        req_log.delete();
        pop_log.delete();
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_req);
          req_log.push_back(imem_req_addr);
          exp_req += 32'd4;
        end
        if (if_valid && if_ready) begin
          chk("if_pc", if_pc, exp_pc);
          chk("if_instr", if_instruction, mdata(if_pc));
          pop_log.push_back(if_pc);
          exp_pc += 32'd4;
          popped++;
        end
      end
    end
    #1;
    if (rst_n && q.size() > 0 && q[0].due <= edge_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic redirect(word_t t);
    redirect_pc    = t;
    redirect_valid = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_q(int n, string tag);
    int k = 0;
    while (q.size() != n && k < 50) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(q.size()), 32'(n));
  endtask

  function automatic word_t at(word_t l[$], int i);
    return (l.size() > i) ? l[i] : 32'hDEADBEEF;
  endfunction

  initial begin
    int p0;
    int k;
    cyc(3);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_if_instr", if_instruction, RV32_NOP);
    chk("rst_if_pc", if_pc, 0);

    rst_n    = 1'b1;
    fetch_en = 1'b1;
    cyc(30);
    chk("first_if_pc", at(pop_log, 0), 0);
    chk("first_req1", at(req_log, 1), 32'h4);
    chk("first_lat", 32'(first_vld - first_acc), 2);
    p0 = popped;
    cyc(20);
    chk("throughput", 32'(popped - p0), 20);

    if_ready = 1'b0;
    cyc(10);
    chk("stall_credit", 32'(issued - popped), 4);
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    if_ready = 1'b1;
    cyc(10);

    fetch_en = 1'b0;
    cyc(4);
    chk("hold_req_valid", 32'(imem_req_valid), 0);
    chk("hold_drained", 32'(if_valid), 0);
    fetch_en = 1'b1;
    cyc(5);

    lat = 3;
    wait_q(3, "wait_out3");
    redirect(32'h100);
    chk("flush_empty", 32'(if_valid), 0);
    cyc(15);
    chk("redir_req0", at(req_log, 0), 32'h100);
    chk("redir_pop0", at(pop_log, 0), 32'h100);

    lat = 1;
    cyc(6);
    k = 0;
    while (!(imem_rsp_valid && imem_req_valid) && k < 50) begin
      cyc(1);
      k++;
    end
    chk("same_cyc_found", 32'(imem_rsp_valid), 1);
    redirect(32'h102);
    cyc(10);
    chk("mis_req0", at(req_log, 0), 32'h100);
    chk("mis_pop0", at(pop_log, 0), 32'h100);

    redirect(32'h200);
    redirect(32'h300);
    cyc(10);
    chk("b2b_req0", at(req_log, 0), 32'h300);
    chk("b2b_pop0", at(pop_log, 0), 32'h300);

    redirect(32'hFFFFFFF8);
    cyc(10);
    chk("wrap_req0", at(req_log, 0), 32'hFFFFFFF8);
    chk("wrap_req1", at(req_log, 1), 32'hFFFFFFFC);
    chk("wrap_req2", at(req_log, 2), 32'h0);
    chk("wrap_pop2", at(pop_log, 2), 32'h0);

    lat = 3;
    wait_q(2, "wait_out2");
    rst_n = 1'b0;
    cyc(1);
    chk("mrst_req_valid", 32'(imem_req_valid), 0);
    chk("mrst_if_valid", 32'(if_valid), 0);
    chk("mrst_if_instr", if_instruction, RV32_NOP);
    chk("mrst_if_pc", if_pc, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(15);
    chk("mrst_req0", at(req_log, 0), 32'h0);
    chk("mrst_pop0", at(pop_log, 0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
